// File: rtl/mioc_dram_arbiter_pkg.sv
// Shared definitions for the MIOC DRAM arbiter: FSM encodings, bank
// constants, default timing parameters and the strobe decode helper.
package mioc_dram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    COL  = 3'd2,
    RFSH = 3'd3,
    PRE  = 3'd4
  } dram_state_e;

  typedef enum logic [1:0] {
    BUS_Z80 = 2'd0,
    BUS_REQ = 2'd1,
    BUS_DMA = 2'd2,
    BUS_REL = 2'd3
  } bus_state_e;

  localparam logic BANK_CAS1 = 1'b0;
  localparam logic BANK_CAS2 = 1'b1;

  localparam int PRECHARGE_CYC_DEF = 1;
  localparam int RFSH_CYC_DEF      = 2;
  localparam int REFRESH_LIMIT_DEF = 48;

  typedef struct packed {
    logic ras_n;
    logic cas1_n;
    logic cas2_n;
    logic mux;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{ras_n: 1'b1, cas1_n: 1'b1, cas2_n: 1'b1, mux: 1'b0};

  // DRAM strobe levels for a given sequencer state; only one CAS can ever be low.
  function automatic strobes_t strobes_for(dram_state_e s, logic bank);
    strobes_t st;
    st = STROBES_IDLE;
    case (s)
      ROW:  st.ras_n = 1'b0;
      COL: begin
        st.ras_n = 1'b0;
        st.mux   = 1'b1;
        if (bank == BANK_CAS2) st.cas2_n = 1'b0;
        else                   st.cas1_n = 1'b0;
      end
      RFSH: st.ras_n = 1'b0;
      default: st = STROBES_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mioc_dram_arbiter_if.sv
// Z80 / 6801 / DRAM signal bundle of the MIOC DRAM arbiter.
// master: the requester side (CPU, DMA, bus acknowledge); slave: the arbiter.
interface mioc_dram_arbiter_if;
  logic       BMREQ_N;
  logic       BRD_N;
  logic       N_BWR;
  logic       BRFSH_N;
  logic       BA15;
  logic       DMA_N;
  logic       DMA_MREQ_N;
  logic       DMA_BANK;
  logic       BUSAK_N;
  logic       BUSRQ_N;
  logic       ADDRBUFEN_N;
  logic       DMA_GNT;
  logic       RAS_N;
  logic       CAS1_N;
  logic       CAS2_N;
  logic       MUX;
  logic [6:0] REF_ADDR;

  modport master (
    output BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, DMA_N, DMA_MREQ_N, DMA_BANK, BUSAK_N,
    input  BUSRQ_N, ADDRBUFEN_N, DMA_GNT, RAS_N, CAS1_N, CAS2_N, MUX, REF_ADDR
  );

  modport slave (
    input  BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, DMA_N, DMA_MREQ_N, DMA_BANK, BUSAK_N,
    output BUSRQ_N, ADDRBUFEN_N, DMA_GNT, RAS_N, CAS1_N, CAS2_N, MUX, REF_ADDR
  );
endinterface

// File: rtl/mioc_dram_arbiter_refresh_wdog.sv
// Refresh watchdog: counts B_PHI cycles since the last refresh entry, raises a
// forced-refresh request at REFRESH_LIMIT (saturating) and owns the refresh
// row counter. Only instantiated when MIOC_REFRESH_WDOG_EN is defined.
module mioc_refresh_wdog
  import mioc_dram_arbiter_pkg::*;
#(
  parameter int REFRESH_LIMIT = REFRESH_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rfsh_start,
  input  logic       forced_done,
  output logic       force_req,
  output logic [6:0] ref_addr
);

  localparam logic [7:0] LIMIT = 8'(REFRESH_LIMIT);

  logic [7:0] cnt_q;

  // Cycles since last refresh entry, held once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst)              cnt_q <= '0;
    else if (rfsh_start)  cnt_q <= '0;
    else if (cnt_q < LIMIT) cnt_q <= cnt_q + 8'd1;
  end

  // Refresh row advances only when a forced refresh finishes.
  always_ff @(posedge clk) begin
    if (rst)              ref_addr <= '0;
    else if (forced_done) ref_addr <= ref_addr + 7'd1;
  end

  assign force_req = (cnt_q == LIMIT);

endmodule

// File: rtl/mioc_dram_arbiter.sv
// MIOC DRAM sequencer and bus arbiter: shares the DRAM between Z80 memory
// cycles, Z80 refresh cycles and 6801 DMA, runs the BUSRQ/BUSAK handshake and
// generates registered RAS/MUX/CAS strobes on whole B_PHI cycles.
// Optional: define MIOC_REFRESH_WDOG_EN to add the forced-refresh watchdog.
module mioc_dram_arbiter
  import mioc_dram_arbiter_pkg::*;
#(
  parameter int PRECHARGE_CYC = PRECHARGE_CYC_DEF,
  parameter int RFSH_CYC      = RFSH_CYC_DEF,
  parameter int REFRESH_LIMIT = REFRESH_LIMIT_DEF
) (
  input  logic                B_PHI,
  input  logic                RST,
  mioc_dram_arbiter_if.slave  bus
);

  localparam logic [1:0] PRE_LAST  = 2'(PRECHARGE_CYC - 1);
  localparam logic [1:0] RFSH_LAST = 2'(RFSH_CYC - 1);

  dram_state_e dram_q, dram_d;
  bus_state_e  bus_q, bus_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        bank_q, bank_d;
  logic        src_dma_q, src_dma_d;
  logic        forced_q, forced_d;

  strobes_t    strb_q, strb_d;
  logic        busrq_n_q, busrq_n_d;
  logic        bufen_n_q, bufen_n_d;
  logic        gnt_q, gnt_d;

  logic        zref_req, cpu_req, dma_req, force_req, dram_idle;
  logic        col_strobe_n;
  logic [6:0]  ref_addr;

  // Read/write strobes are status-only; they do not steer the sequencer.
  logic        unused_status;
  assign unused_status = ^{bus.BRD_N, bus.N_BWR};

  // Request decode; CPU cycles are locked out while DMA owns the bus.
  assign zref_req  = !bus.BMREQ_N && !bus.BRFSH_N;
  assign cpu_req   = !bus.BMREQ_N && bus.BRFSH_N && !gnt_q && !bufen_n_q;
  assign dma_req   = !bus.DMA_MREQ_N && gnt_q;
  assign dram_idle = (dram_q == IDLE);

  // The strobe that opened the access decides how long COL is held.
  assign col_strobe_n = src_dma_q ? bus.DMA_MREQ_N : bus.BMREQ_N;

  // State registers and registered outputs.
  always_ff @(posedge B_PHI) begin
    if (RST) begin
      dram_q    <= IDLE;
      bus_q     <= BUS_Z80;
      cnt_q     <= '0;
      src_dma_q <= 1'b0;
      forced_q  <= 1'b0;
      strb_q    <= STROBES_IDLE;
      busrq_n_q <= 1'b1;
      bufen_n_q <= 1'b0;
      gnt_q     <= 1'b0;
    end else begin
      dram_q    <= dram_d;
      bus_q     <= bus_d;
      cnt_q     <= cnt_d;
      src_dma_q <= src_dma_d;
      forced_q  <= forced_d;
      strb_q    <= strb_d;
      busrq_n_q <= busrq_n_d;
      bufen_n_q <= bufen_n_d;
      gnt_q     <= gnt_d;
    end
  end

  // Bank latch is pure data and needs no reset.
  always_ff @(posedge B_PHI) begin
    bank_q <= bank_d;
  end

  // DRAM sequencer next state: forced refresh > zref > dma > cpu.
  always_comb begin
    dram_d    = dram_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    src_dma_d = src_dma_q;
    forced_d  = forced_q;
    case (dram_q)
      IDLE: begin
        cnt_d = '0;
        if (force_req) begin
          dram_d   = RFSH;
          forced_d = 1'b1;
        end else if (zref_req) begin
          dram_d   = RFSH;
          forced_d = 1'b0;
        end else if (dma_req) begin
          dram_d    = ROW;
          bank_d    = bus.DMA_BANK;
          src_dma_d = 1'b1;
        end else if (cpu_req) begin
          dram_d    = ROW;
          bank_d    = bus.BA15;
          src_dma_d = 1'b0;
        end
      end
      ROW: dram_d = COL;
      COL: begin
        if (col_strobe_n) begin
          dram_d = PRE;
          cnt_d  = '0;
        end
      end
      RFSH: begin
        if (cnt_q == RFSH_LAST) begin
          dram_d = PRE;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          dram_d = IDLE;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: dram_d = IDLE;
    endcase
  end

  // Bus handshake next state; ownership only changes with the DRAM idle.
  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      BUS_Z80: if (!bus.DMA_N) bus_d = BUS_REQ;
      BUS_REQ: begin
        if (bus.DMA_N)                        bus_d = BUS_REL;
        else if (!bus.BUSAK_N && dram_idle)   bus_d = BUS_DMA;
      end
      BUS_DMA: if (bus.DMA_N && dram_idle) bus_d = BUS_REL;
      BUS_REL: if (bus.BUSAK_N) bus_d = BUS_Z80;
      default: bus_d = BUS_Z80;
    endcase
  end

  // Output decode from next state, so every output leaves a flop.
  always_comb begin
    strb_d    = strobes_for(dram_d, bank_d);
    busrq_n_d = !((bus_d == BUS_REQ) || (bus_d == BUS_DMA));
    bufen_n_d = (bus_d == BUS_DMA) || (bus_d == BUS_REL);
    gnt_d     = (bus_d == BUS_DMA);
  end

`ifdef MIOC_REFRESH_WDOG_EN
  logic rfsh_start, forced_done;
  assign rfsh_start  = dram_idle && (dram_d == RFSH);
  assign forced_done = (dram_q == RFSH) && (dram_d == PRE) && forced_q;

  mioc_refresh_wdog #(
    .REFRESH_LIMIT (REFRESH_LIMIT)
  ) u_wdog (
    .clk         (B_PHI),
    .rst         (RST),
    .rfsh_start  (rfsh_start),
    .forced_done (forced_done),
    .force_req   (force_req),
    .ref_addr    (ref_addr)
  );
`else
  // Without the watchdog refresh comes only from the Z80.
  logic unused_wdog;
  assign unused_wdog = ^{forced_q, 8'(REFRESH_LIMIT)};
  assign force_req   = 1'b0;
  assign ref_addr    = '0;
`endif

  assign bus.RAS_N       = strb_q.ras_n;
  assign bus.CAS1_N      = strb_q.cas1_n;
  assign bus.CAS2_N      = strb_q.cas2_n;
  assign bus.MUX         = strb_q.mux;
  assign bus.BUSRQ_N     = busrq_n_q;
  assign bus.ADDRBUFEN_N = bufen_n_q;
  assign bus.DMA_GNT     = gnt_q;
  assign bus.REF_ADDR    = ref_addr;

endmodule

// File: tb/tb_mioc_dram_arbiter.sv
// Bench for mioc_dram_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mioc_dram_arbiter;

  localparam int PRE_C = 1;
  localparam int RF_C  = 2;
  localparam int LIMIT = 48;
`ifdef MIOC_REFRESH_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic B_PHI;
  logic RST;
  mioc_dram_arbiter_if bus ();

  mioc_dram_arbiter #(
    .PRECHARGE_CYC (PRE_C),
    .RFSH_CYC      (RF_C),
    .REFRESH_LIMIT (LIMIT)
  ) dut (
    .B_PHI (B_PHI),
    .RST   (RST),
    .bus   (bus)
  );

  initial begin
    B_PHI = 1'b0;
    forever #5 B_PHI = ~B_PHI;
  end

  int checks;
  int failures;

  // Behavioural model: an access is described by its age in cycles
  // (1 = row phase, 2 = column phase), a refresh by cycles still to run,
  // precharge by cycles still to run; bus ownership by three flags.
  int       acc_age, rf_left, pre_left, since;
  bit       m_bank, m_src_dma, m_forced;
  bit       m_rq, m_gnt, m_bufoff;
  bit [6:0] m_refa;
  bit       mvalid;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit zref, cpu, dma, frc, idle, start_rf, strobe_hi;
    if (RST) begin
      acc_age = 0; rf_left = 0; pre_left = 0; since = 0;
      m_bank = 0; m_src_dma = 0; m_forced = 0;
      m_rq = 0; m_gnt = 0; m_bufoff = 0; m_refa = '0;
      mvalid = 1;
      return;
    end
    zref = !bus.BMREQ_N && !bus.BRFSH_N;
    cpu  = !bus.BMREQ_N && bus.BRFSH_N && !m_gnt && !m_bufoff;
    dma  = !bus.DMA_MREQ_N && m_gnt;
    frc  = WDOG && (since == LIMIT);
    idle = (acc_age == 0) && (rf_left == 0) && (pre_left == 0);
    start_rf = 0;
    if (idle) begin
      if (frc || zref) begin
        rf_left = RF_C; m_forced = frc; start_rf = 1;
      end else if (dma) begin
        acc_age = 1; m_bank = bus.DMA_BANK; m_src_dma = 1;
      end else if (cpu) begin
        acc_age = 1; m_bank = bus.BA15; m_src_dma = 0;
      end
    end else if (acc_age == 1) begin
      acc_age = 2;
    end else if (acc_age == 2) begin
      strobe_hi = m_src_dma ? bus.DMA_MREQ_N : bus.BMREQ_N;
      if (strobe_hi) begin acc_age = 0; pre_left = PRE_C; end
    end else if (rf_left > 0) begin
      rf_left--;
      if (rf_left == 0) begin
        pre_left = PRE_C;
        if (m_forced) m_refa = m_refa + 7'd1;
      end
    end else if (pre_left > 0) begin
      pre_left--;
    end
    // bus ownership, decided on the DRAM state before this edge
    if (!m_rq && !m_bufoff) begin
      if (!bus.DMA_N) m_rq = 1;
    end else if (m_rq && !m_gnt) begin
      if (bus.DMA_N) begin m_rq = 0; m_bufoff = 1; end
      else if (!bus.BUSAK_N && idle) begin m_gnt = 1; m_bufoff = 1; end
    end else if (m_gnt) begin
      if (bus.DMA_N && idle) begin m_rq = 0; m_gnt = 0; end
    end else begin
      if (bus.BUSAK_N) m_bufoff = 0;
    end
    if (WDOG) since = start_rf ? 0 : ((since < LIMIT) ? since + 1 : since);
  endtask

  task automatic compare_model();
    chk("RAS_N",       8'(bus.RAS_N),       8'(!(acc_age > 0 || rf_left > 0)));
    chk("MUX",         8'(bus.MUX),         8'(acc_age == 2));
    chk("CAS1_N",      8'(bus.CAS1_N),      8'(!(acc_age == 2 && !m_bank)));
    chk("CAS2_N",      8'(bus.CAS2_N),      8'(!(acc_age == 2 && m_bank)));
    chk("BUSRQ_N",     8'(bus.BUSRQ_N),     8'(!m_rq));
    chk("DMA_GNT",     8'(bus.DMA_GNT),     8'(m_gnt));
    chk("ADDRBUFEN_N", 8'(bus.ADDRBUFEN_N), 8'(m_bufoff));
    chk("REF_ADDR",    8'(bus.REF_ADDR),    8'(m_refa));
    chk("cas_exclusive", 8'(!(bus.CAS1_N == 1'b0 && bus.CAS2_N == 1'b0)), 8'd1);
  endtask

  task automatic tick();
    @(posedge B_PHI);
    model_step();
    #1;
    if (mvalid) compare_model();
  endtask

  task automatic idle_inputs();
    bus.BMREQ_N = 1; bus.BRD_N = 1; bus.N_BWR = 1; bus.BRFSH_N = 1; bus.BA15 = 0;
    bus.DMA_N = 1; bus.DMA_MREQ_N = 1; bus.DMA_BANK = 0; bus.BUSAK_N = 1;
  endtask

  initial begin
    int ras_low;
    checks = 0; failures = 0; mvalid = 0;
    RST = 1;
    idle_inputs();

    // reset state
    tick(); tick();
    chk("rst_RAS_N", 8'(bus.RAS_N), 8'd1);
    chk("rst_CAS1_N", 8'(bus.CAS1_N), 8'd1);
    chk("rst_CAS2_N", 8'(bus.CAS2_N), 8'd1);
    chk("rst_MUX", 8'(bus.MUX), 8'd0);
    chk("rst_BUSRQ_N", 8'(bus.BUSRQ_N), 8'd1);
    chk("rst_ADDRBUFEN_N", 8'(bus.ADDRBUFEN_N), 8'd0);
    chk("rst_DMA_GNT", 8'(bus.DMA_GNT), 8'd0);
    chk("rst_REF_ADDR", 8'(bus.REF_ADDR), 8'd0);
    RST = 0;
    tick();

    // CPU read, bank 0, strobe held three edges
    bus.BMREQ_N = 0; bus.BRD_N = 0; bus.BA15 = 0;
    tick();
    chk("cpu_ras_p1", 8'(bus.RAS_N), 8'd0);
    chk("cpu_mux_p1", 8'(bus.MUX), 8'd0);
    tick();
    chk("cpu_mux_p2", 8'(bus.MUX), 8'd1);
    chk("cpu_cas1_p2", 8'(bus.CAS1_N), 8'd0);
    chk("cpu_cas2_p2", 8'(bus.CAS2_N), 8'd1);
    tick();
    chk("cpu_cas1_p3", 8'(bus.CAS1_N), 8'd0);
    bus.BMREQ_N = 1; bus.BRD_N = 1;
    tick();
    chk("cpu_pre_ras", 8'(bus.RAS_N), 8'd1);
    chk("cpu_pre_cas1", 8'(bus.CAS1_N), 8'd1);
    tick();

    // Z80 refresh cycle
    bus.BMREQ_N = 0; bus.BRFSH_N = 0;
    tick();
    chk("zref_ras_1", 8'(bus.RAS_N), 8'd0);
    chk("zref_cas1", 8'(bus.CAS1_N), 8'd1);
    chk("zref_cas2", 8'(bus.CAS2_N), 8'd1);
    chk("zref_mux", 8'(bus.MUX), 8'd0);
    bus.BMREQ_N = 1; bus.BRFSH_N = 1;
    tick();
    chk("zref_ras_2", 8'(bus.RAS_N), 8'd0);
    tick();
    chk("zref_ras_pre", 8'(bus.RAS_N), 8'd1);
    tick();

    // DMA handshake and a bank-1 DMA access
    bus.DMA_N = 0;
    tick();
    chk("dma_busrq", 8'(bus.BUSRQ_N), 8'd0);
    chk("dma_gnt_wait", 8'(bus.DMA_GNT), 8'd0);
    bus.BUSAK_N = 0;
    tick();
    chk("dma_bufen", 8'(bus.ADDRBUFEN_N), 8'd1);
    chk("dma_gnt", 8'(bus.DMA_GNT), 8'd1);
    bus.DMA_MREQ_N = 0; bus.DMA_BANK = 1;
    tick();
    chk("dma_ras", 8'(bus.RAS_N), 8'd0);
    tick();
    chk("dma_cas2", 8'(bus.CAS2_N), 8'd0);
    chk("dma_cas1", 8'(bus.CAS1_N), 8'd1);
    bus.DMA_MREQ_N = 1;
    tick();

    // CPU request while DMA owns the bus must stay off the DRAM
    bus.BMREQ_N = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blocked_ras", 8'(bus.RAS_N), 8'd1);
    end
    bus.BMREQ_N = 1;

    // release
    bus.DMA_N = 1;
    tick();
    chk("rel_busrq", 8'(bus.BUSRQ_N), 8'd1);
    chk("rel_gnt", 8'(bus.DMA_GNT), 8'd0);
    chk("rel_bufen_held", 8'(bus.ADDRBUFEN_N), 8'd1);
    tick();
    chk("rel_bufen_wait", 8'(bus.ADDRBUFEN_N), 8'd1);
    bus.BUSAK_N = 1;
    tick();
    chk("rel_bufen_done", 8'(bus.ADDRBUFEN_N), 8'd0);

    // reset in the middle of a DMA column cycle
    bus.DMA_N = 0;
    tick();
    bus.BUSAK_N = 0;
    tick();
    bus.DMA_MREQ_N = 0; bus.DMA_BANK = 0;
    tick();
    tick();
    chk("midcol_cas1", 8'(bus.CAS1_N), 8'd0);
    RST = 1;
    tick();
    chk("midrst_ras", 8'(bus.RAS_N), 8'd1);
    chk("midrst_cas1", 8'(bus.CAS1_N), 8'd1);
    chk("midrst_cas2", 8'(bus.CAS2_N), 8'd1);
    chk("midrst_busrq", 8'(bus.BUSRQ_N), 8'd1);
    chk("midrst_gnt", 8'(bus.DMA_GNT), 8'd0);
    RST = 0;
    idle_inputs();
    tick();

    // long DMA hold with no Z80 refresh
    bus.DMA_N = 0;
    tick();
    bus.BUSAK_N = 0;
    tick();
    ras_low = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.RAS_N == 1'b0) ras_low++;
    end
    chk("wdog_ras_cycles", 8'(ras_low), WDOG ? 8'(RF_C) : 8'd0);
    chk("wdog_ref_addr", 8'(bus.REF_ADDR), WDOG ? 8'd1 : 8'd0);
    bus.DMA_N = 1;
    tick();
    bus.BUSAK_N = 1;
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      RST             = ($urandom_range(0, 299) == 0);
      bus.BMREQ_N     = ($urandom_range(0, 2) != 0);
      bus.BRFSH_N     = ($urandom_range(0, 3) != 0);
      bus.BRD_N       = 1'($urandom_range(0, 1));
      bus.N_BWR       = 1'($urandom_range(0, 1));
      bus.BA15        = 1'($urandom_range(0, 1));
      bus.DMA_MREQ_N  = ($urandom_range(0, 2) != 0);
      bus.DMA_BANK    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bus.DMA_N = ~bus.DMA_N;
      if ($urandom_range(0, 1) == 1) bus.BUSAK_N = !m_rq;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mioc_dram_arbiter.md
Name: mioc_dram_arbiter

Overview:
- DRAM access sequencer and bus arbiter inside mioc_top.
- Shares the ADAM DRAM between three requesters: Z80 CPU memory cycles, Z80 refresh cycles, and 6801 DMA.
- Runs the Z80 bus-request/acknowledge handshake for DMA and drives ADDRBUFEN_N.
- Generates RAS_N, MUX, CAS1_N and CAS2_N on whole B_PHI cycles.

Parameters:
- PRECHARGE_CYC, default 1: B_PHI cycles with RAS_N high after any access (1..3).
- RFSH_CYC, default 2: B_PHI cycles RAS_N is held low for a refresh (1..3).
- REFRESH_LIMIT, default 48: B_PHI cycles without a refresh before a forced refresh (optional feature only).

Ports:
- B_PHI  in  1  Z80 clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- BMREQ_N  in  1  Z80 memory request.
- BRD_N  in  1  Z80 read strobe (held for status only).
- N_BWR  in  1  Z80 write strobe (held for status only).
- BRFSH_N  in  1  Z80 refresh qualifier.
- BA15  in  1  bank select: 0 selects CAS1_N, 1 selects CAS2_N.
- DMA_N  in  1  6801 DMA bus request.
- DMA_MREQ_N  in  1  6801 memory strobe while granted.
- DMA_BANK  in  1  bank select for DMA accesses.
- BUSAK_N  in  1  Z80 bus acknowledge.
- BUSRQ_N  out  1  Z80 bus request.
- ADDRBUFEN_N  out  1  Z80 address buffer enable; high while DMA owns the bus.
- DMA_GNT  out  1  DMA grant to the 6801 side.
- RAS_N, CAS1_N, CAS2_N  out  1 each  DRAM strobes.
- MUX  out  1  0 = row address, 1 = column address.
- REF_ADDR  out  7  internal refresh row counter.

Behaviour:
- Reset values: BUSRQ_N=1, ADDRBUFEN_N=0, DMA_GNT=0, RAS_N=1, CAS1_N=1, CAS2_N=1, MUX=0, REF_ADDR=0.
- Both FSMs enter IDLE / BUS_Z80. Reset asserted mid-access forces these values on the next edge.
- Request decode, sampled at the rising edge:
  - zref: BMREQ_N=0 and BRFSH_N=0.
  - cpu: BMREQ_N=0, BRFSH_N=1, not granted.
  - dma: DMA_MREQ_N=0 and granted.
  - Priority: forced refresh > zref > dma > cpu.
- DRAM FSM:
  - IDLE: no strobes. With a request, go to ROW (or RFSH for a refresh). Latch the bank from BA15, or DMA_BANK for dma.
  - ROW: RAS_N=0, MUX=0, exactly 1 cycle, then COL.
  - COL: RAS_N=0, MUX=1, CAS of the latched bank =0. Stay while the strobe that started the access (BMREQ_N or DMA_MREQ_N) is low. On release go to PRE.
  - RFSH: RAS_N=0, both CAS=1, for RFSH_CYC cycles, then PRE. REF_ADDR increments by 1 (mod 128) on exit of a forced refresh only.
  - PRE: all strobes high for PRECHARGE_CYC cycles, then IDLE.
  - Latency: request edge to RAS_N low is 1 cycle; to CAS low is 2 cycles.
  - Strobes are registered and glitch-free. CAS1_N and CAS2_N are never low together.
  - A request that deasserts while in ROW still completes the COL cycle once, then goes to PRE.
- Bus FSM:
  - BUS_Z80: DMA_N=0 → BUS_REQ.
  - BUS_REQ: BUSRQ_N=0. On BUSAK_N=0 with the DRAM FSM in IDLE → BUS_DMA.
  - BUS_DMA: BUSRQ_N=0, ADDRBUFEN_N=1, DMA_GNT=1. On DMA_N=1 → BUS_REL, but only in DRAM IDLE; an access in flight completes first.
  - BUS_REL: BUSRQ_N=1, DMA_GNT=0, ADDRBUFEN_N stays 1 until BUSAK_N=1 is sampled, then BUS_Z80.
  - DMA_N released during BUS_REQ (before BUSAK_N) → directly BUS_REL.
  - DMA_N asserted again in BUS_REL is held off until BUS_Z80 is reached.
- cpu requests are ignored whenever DMA_GNT=1 or ADDRBUFEN_N=1.

Optional Feature:
- Macro: MIOC_REFRESH_WDOG_EN.
- Defined:
  - An 8-bit counter counts B_PHI cycles and clears on any RFSH entry.
  - At REFRESH_LIMIT it raises a forced-refresh request, taken at the next DRAM IDLE (so during DMA as well).
  - The counter saturates at REFRESH_LIMIT; it does not wrap.
- Undefined:
  - No counter and no forced refresh.
  - Refresh comes only from Z80 zref cycles; REF_ADDR is held at 0.

Decomposition:
- mioc_pkg: DRAM FSM state encoding (IDLE, ROW, COL, RFSH, PRE), bus FSM encoding (BUS_Z80, BUS_REQ, BUS_DMA, BUS_REL), bank constants, and the default values of PRECHARGE_CYC, RFSH_CYC and REFRESH_LIMIT.
- One sub-module: mioc_refresh_wdog, which holds the counter and REF_ADDR and is instantiated only under the macro.

Test Plan:
- CPU read: BMREQ_N=0, BRD_N=0, BA15=0 held 3 cycles → RAS_N low at +1, MUX=1 and CAS1_N low at +2, CAS2_N stays 1; after release, 1 precharge cycle.
- Z80 refresh: BMREQ_N=0, BRFSH_N=0 → RAS_N low for 2 cycles, CAS1_N=CAS2_N=1, MUX=0.
- DMA handshake: DMA_N=0 → BUSRQ_N=0. BUSAK_N=0 → next edge ADDRBUFEN_N=1, DMA_GNT=1. DMA_MREQ_N=0 with DMA_BANK=1 → CAS2_N low. DMA_N=1 → BUSRQ_N=1, then after BUSAK_N=1, ADDRBUFEN_N=0.
- Grant blocking: cpu request (BMREQ_N=0) during BUS_DMA → no strobe activity.
- Reset mid-COL: RST=1 → all strobes 1 on the next edge, BUSRQ_N=1, DMA_GNT=0.
- With MIOC_REFRESH_WDOG_EN and REFRESH_LIMIT=48: hold DMA 60 cycles with no zref → forced RFSH at cycle 48 (±PRE/access wait), REF_ADDR goes 0→1. Without the macro → no RFSH.
